// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch time base: divides the prescaler tick to centiseconds and keeps a BCD MM:SS:CC count.
// Optional lap capture is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter #(
   parameter int TICKS_PER_CS = 1000,
   parameter int MAX_MIN      = 59
) (
   input  logic        sysclk,
   input  logic        i_rst,
   input  logic        i_tick,
   input  logic        i_start_stop,
   input  logic        i_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic        i_lap,
   output logic [23:0] o_lap_bcd,
   output logic        o_lap_valid,
`endif
   output logic [7:0]  o_min_bcd,
   output logic [7:0]  o_sec_bcd,
   output logic [7:0]  o_cs_bcd,
   output logic        o_running,
   output logic        o_wrap
);

   localparam int SUB_W = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
   localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_CS - 1);
   localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic [SUB_W-1:0] sub_r;
   logic [SUB_W-1:0] sub_next_s;
   logic [7:0]       min_r, sec_r, cs_r;
   logic [7:0]       min_next_s, sec_next_s, cs_next_s;
   logic             running_r;
   logic             wrap_r;
   logic             wrap_s;
   logic             count_en_s;
   logic             cs_adv_s;

   // Two-digit BCD increment; callers handle the upper wrap point so no digit exceeds 9.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         bcd_inc = {v[7:4] + 4'd1, 4'd0};
      end else begin
         bcd_inc = {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   // Run/pause sequencing; clear overrides any start/stop request.
   always_comb begin
      next_state_s = state_r;
      if (i_clear) begin
         next_state_s = ST_IDLE;
      end else if (i_start_stop) begin
         case (state_r)
            ST_IDLE:  next_state_s = ST_RUN;
            ST_RUN:   next_state_s = ST_PAUSE;
            ST_PAUSE: next_state_s = ST_RUN;
            default:  next_state_s = ST_IDLE;
         endcase
      end else begin
         next_state_s = state_r;
      end
   end

   // Tick divider and full MM:SS:CC carry chain, resolved in a single cycle.
   always_comb begin
      count_en_s = (state_r == ST_RUN) && i_tick;
      cs_adv_s   = count_en_s && (sub_r == SUB_MAX);
      sub_next_s = sub_r;
      cs_next_s  = cs_r;
      sec_next_s = sec_r;
      min_next_s = min_r;
      wrap_s     = 1'b0;
      if (count_en_s) begin
         if (sub_r == SUB_MAX) begin
            sub_next_s = '0;
         end else begin
            sub_next_s = sub_r + SUB_W'(1);
         end
      end else begin
         sub_next_s = sub_r;
      end
      if (cs_adv_s) begin
         if (cs_r == 8'h99) begin
            cs_next_s = 8'h00;
            if (sec_r == 8'h59) begin
               sec_next_s = 8'h00;
               if (min_r == MAX_MIN_BCD) begin
                  min_next_s = 8'h00;
                  wrap_s     = 1'b1;
               end else begin
                  min_next_s = bcd_inc(min_r);
               end
            end else begin
               sec_next_s = bcd_inc(sec_r);
            end
         end else begin
            cs_next_s = bcd_inc(cs_r);
         end
      end else begin
         cs_next_s = cs_r;
      end
   end

   // State, counters and registered status outputs.
   always_ff @(posedge sysclk or posedge i_rst) begin
      if (i_rst) begin
         state_r   <= ST_IDLE;
         sub_r     <= '0;
         min_r     <= 8'h00;
         sec_r     <= 8'h00;
         cs_r      <= 8'h00;
         running_r <= 1'b0;
         wrap_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         running_r <= (next_state_s == ST_RUN);
         if (i_clear) begin
            sub_r  <= '0;
            min_r  <= 8'h00;
            sec_r  <= 8'h00;
            cs_r   <= 8'h00;
            wrap_r <= 1'b0;
         end else begin
            sub_r  <= sub_next_s;
            min_r  <= min_next_s;
            sec_r  <= sec_next_s;
            cs_r   <= cs_next_s;
            wrap_r <= wrap_s;
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic [23:0] lap_bcd_r;
   logic        lap_valid_r;

   // Lap snapshot of the pre-edge count; the running count is untouched.
   always_ff @(posedge sysclk or posedge i_rst) begin
      if (i_rst) begin
         lap_bcd_r   <= 24'h000000;
         lap_valid_r <= 1'b0;
      end else if (i_clear) begin
         lap_valid_r <= 1'b0;
      end else if (i_lap && (state_r == ST_RUN)) begin
         lap_bcd_r   <= {min_r, sec_r, cs_r};
         lap_valid_r <= 1'b1;
      end else begin
         lap_valid_r <= lap_valid_r;
      end
   end

   assign o_lap_bcd   = lap_bcd_r;
   assign o_lap_valid = lap_valid_r;
`endif

   assign o_min_bcd = min_r;
   assign o_sec_bcd = sec_r;
   assign o_cs_bcd  = cs_r;
   assign o_running = running_r;
   assign o_wrap    = wrap_r;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter with TICKS_PER_CS=4, MAX_MIN=1.
// Define STOPWATCH_LAP_EN to also exercise lap capture.
module tb_stopwatch_bcd_counter;

   logic        sysclk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_tick = 1'b0;
   logic        i_start_stop = 1'b0;
   logic        i_clear = 1'b0;
   logic        i_lap = 1'b0;
   logic [7:0]  o_min_bcd, o_sec_bcd, o_cs_bcd;
   logic        o_running, o_wrap;
   logic [23:0] lap_bcd;
   logic        lap_valid;

   stopwatch_bcd_counter #(.TICKS_PER_CS(4), .MAX_MIN(1)) dut (
      .sysclk       (sysclk),
      .i_rst        (i_rst),
      .i_tick       (i_tick),
      .i_start_stop (i_start_stop),
      .i_clear      (i_clear),
`ifdef STOPWATCH_LAP_EN
      .i_lap        (i_lap),
      .o_lap_bcd    (lap_bcd),
      .o_lap_valid  (lap_valid),
`endif
      .o_min_bcd    (o_min_bcd),
      .o_sec_bcd    (o_sec_bcd),
      .o_cs_bcd     (o_cs_bcd),
      .o_running    (o_running),
      .o_wrap       (o_wrap)
   );

`ifndef STOPWATCH_LAP_EN
   assign lap_bcd   = 24'h000000;
   assign lap_valid = 1'b0;
`endif

   always #5 sysclk = ~sysclk;

   typedef struct {
      int          cyc;
      string       name;
      logic [7:0]  mn, sc, cs;
      logic        run, wrap;
      logic [23:0] lap;
      logic        lapv;
      bit          chk_lap;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge sysclk) cyc++;

   // Monitor: compares each expectation against the outputs after its edge.
   always @(negedge sysclk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [25:0] act, req;
         e = q.pop_front();
         checks++;
         act = {o_min_bcd, o_sec_bcd, o_cs_bcd, o_running, o_wrap};
         req = {e.mn, e.sc, e.cs, e.run, e.wrap};
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: stale expectation cyc %0d seen at %0d", e.name, e.cyc, cyc);
         end else if (act !== req || (e.chk_lap && {lap_bcd, lap_valid} !== {e.lap, e.lapv})) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h run=%b wrap=%b lap=%h/%b, want %h:%h:%h run=%b wrap=%b lap=%h/%b",
                     e.name, o_min_bcd, o_sec_bcd, o_cs_bcd, o_running, o_wrap, lap_bcd, lap_valid,
                     e.mn, e.sc, e.cs, e.run, e.wrap, e.lap, e.lapv);
         end
      end
   end

   task automatic drive(input logic tk, input logic ss, input logic clr, input logic lp);
      i_tick = tk; i_start_stop = ss; i_clear = clr; i_lap = lp;
      @(posedge sysclk);
      #1;
      i_tick = 1'b0; i_start_stop = 1'b0; i_clear = 1'b0; i_lap = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_lap(input string nm, input logic [7:0] m, input logic [7:0] s,
                             input logic [7:0] c, input logic r, input logic w,
                             input logic [23:0] lb, input logic lv, input bit cl);
      exp_t e;
      e.cyc = cyc; e.name = nm; e.mn = m; e.sc = s; e.cs = c; e.run = r; e.wrap = w;
      e.lap = lb; e.lapv = lv; e.chk_lap = cl;
      q.push_back(e);
   endtask

   task automatic expect_cnt(input string nm, input logic [7:0] m, input logic [7:0] s,
                             input logic [7:0] c, input logic r, input logic w);
      expect_lap(nm, m, s, c, r, w, 24'h000000, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (3) @(posedge sysclk);
      #1 i_rst = 1'b0;
      expect_cnt("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      ticks(10);
      expect_cnt("idle_ticks", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      drive(1'b0, 1'b1, 1'b0, 1'b0);
      expect_cnt("start", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      ticks(3);
      expect_cnt("3_ticks", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      ticks(1);
      expect_cnt("first_cs", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
      ticks(36);
      expect_cnt("cs_units_carry", 8'h00, 8'h00, 8'h10, 1'b1, 1'b0);
      ticks(360);
      expect_cnt("first_sec", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);

      ticks(23596);
      expect_cnt("00_59_99", 8'h00, 8'h59, 8'h99, 1'b1, 1'b0);
      ticks(4);
      expect_cnt("min_carry", 8'h01, 8'h00, 8'h00, 1'b1, 1'b0);
      ticks(23996);
      expect_cnt("01_59_99", 8'h01, 8'h59, 8'h99, 1'b1, 1'b0);
      ticks(3);
      expect_cnt("pre_wrap", 8'h01, 8'h59, 8'h99, 1'b1, 1'b0);
      ticks(1);
      expect_cnt("wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      expect_cnt("wrap_pulse_end", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

      drive(1'b0, 1'b0, 1'b1, 1'b0);
      expect_cnt("clear_run", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(6);
      expect_cnt("6_ticks", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      expect_cnt("pause", 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
      ticks(5);
      expect_cnt("pause_ticks", 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(1);
      expect_cnt("resume_1", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);
      ticks(1);
      expect_cnt("partial_kept", 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);

      ticks(3);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      expect_cnt("stop_tick_counts", 8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      expect_cnt("start_tick_ignored", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
      ticks(3);
      expect_cnt("after_resume_3", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0);
      ticks(1);
      expect_cnt("after_resume_4", 8'h00, 8'h00, 8'h04, 1'b1, 1'b0);

      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(1388);
      expect_cnt("00_03_47", 8'h00, 8'h03, 8'h47, 1'b1, 1'b0);
      ticks(2);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      expect_cnt("clear_wins", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      ticks(1);
      expect_cnt("idle_after_clear", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(3);
      expect_cnt("sub_cleared_3", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      ticks(1);
      expect_cnt("sub_cleared_4", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);

`ifdef STOPWATCH_LAP_EN
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      expect_lap("lap_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      ticks(500);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      expect_lap("lap_capture", 8'h00, 8'h01, 8'h25, 1'b1, 1'b0, 24'h000125, 1'b1, 1'b1);
      ticks(4);
      expect_lap("lap_hold", 8'h00, 8'h01, 8'h26, 1'b1, 1'b0, 24'h000125, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      expect_lap("lap_pause_ignored", 8'h00, 8'h01, 8'h26, 1'b0, 1'b0, 24'h000125, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      expect_cnt("lap_clear_wins", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      if (lap_valid !== 1'b0) begin
         errors++;
         $display("FAIL lap_valid_clear: got %b want 0", lap_valid);
      end
      checks++;
`endif

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge sysclk);
      @(negedge sysclk);
      #1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
